processor_mc: RTL and testbench

Parametrised multi-cycle 16-bit-instruction processor core with a single handshaked memory port shared by instruction fetch and data access. It replaces the single-cycle core and its fixed-latency, dual-port memory coupling. Data width, address width and register count are configurable. A state machine sequences fetch, execute and memory phases, and a HALT state stops execution.

---
 rtl/processor_mc_pkg.sv | 40 ++++
 rtl/register_file_n.sv | 36 +++
 rtl/processor_mc.sv | 150 +++++++++++++++
 tb/tb_processor_mc.sv | 362 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/processor_mc_pkg.sv
// Shared definitions for the multi-cycle core: opcode and state encodings
// plus the bit positions of the 16-bit instruction fields.
package processor_mc_pkg;

  localparam int unsigned INSTR_W = 16;
  localparam int unsigned OP_MSB  = 15;
  localparam int unsigned OP_LSB  = 12;
  localparam int unsigned RD_MSB  = 11;
  localparam int unsigned RD_LSB  = 8;
  localparam int unsigned RS1_MSB = 7;
  localparam int unsigned RS1_LSB = 4;
  localparam int unsigned RS2_MSB = 3;
  localparam int unsigned RS2_LSB = 0;
  localparam int unsigned IMM_MSB = 7;
  localparam int unsigned IMM_LSB = 0;

  // Codes 0xB..0xE are deliberately absent: they decode as NOP.
  typedef enum logic [3:0] {
    OP_NOP  = 4'h0,
    OP_ADD  = 4'h1,
    OP_SUB  = 4'h2,
    OP_AND  = 4'h3,
    OP_OR   = 4'h4,
    OP_XOR  = 4'h5,
    OP_LDI  = 4'h6,
    OP_LD   = 4'h7,
    OP_ST   = 4'h8,
    OP_BZ   = 4'h9,
    OP_JR   = 4'hA,
    OP_HALT = 4'hF
  } opcode_e;

  typedef enum logic [1:0] {
    S_FETCH,
    S_EXEC,
    S_MEM,
    S_HALT
  } state_e;

endpackage

// File: rtl/register_file_n.sv
// General-purpose register file: one synchronous write port, two
// asynchronous read ports, asynchronous reset of every entry to zero.
//   clk, reset_i            clock, async active-high reset
//   we_i/waddr_i/wdata_i    write port
//   raddr_a_i/rdata_a_o     read port A
//   raddr_b_i/rdata_b_o     read port B
module register_file_n #(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned NUM_REGS = 4,
  localparam int unsigned IDX_W   = $clog2(NUM_REGS)
) (
  input  logic              clk,
  input  logic              reset_i,
  input  logic              we_i,
  input  logic [IDX_W-1:0]  waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [IDX_W-1:0]  raddr_a_i,
  input  logic [IDX_W-1:0]  raddr_b_i,
  output logic [DATA_W-1:0] rdata_a_o,
  output logic [DATA_W-1:0] rdata_b_o
);

  logic [DATA_W-1:0] regs_q [NUM_REGS];

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      for (int unsigned i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
    end else if (we_i) begin
      regs_q[waddr_i] <= wdata_i;
    end
  end

  assign rdata_a_o = regs_q[raddr_a_i];
  assign rdata_b_o = regs_q[raddr_b_i];

endmodule

// File: rtl/processor_mc.sv
// Multi-cycle 16-bit-instruction core sharing one handshaked memory port
// between instruction fetch and data access.
//   clk, reset_i      clock, async active-high reset
//   mem_req_o/we_o    request (held until ack) and write strobe
//   mem_addr_o        fetch address (PC) or data address (rs1)
//   mem_wdata_o       store data (rs2) during ST, zero otherwise
//   mem_rdata_i       read data, sampled on the ack edge
//   mem_ack_i         completes a transfer together with mem_req_o
//   halted_o, pc_o    HALT status and debug PC
module processor_mc
  import processor_mc_pkg::*;
#(
  parameter int unsigned DATA_W   = 16,
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned NUM_REGS = 4
) (
  input  logic              clk,
  input  logic              reset_i,
  output logic              mem_req_o,
  output logic              mem_we_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i,
  input  logic              mem_ack_i,
  output logic              halted_o,
  output logic [ADDR_W-1:0] pc_o
);

  localparam int unsigned IDX_W = $clog2(NUM_REGS);

  state_e               state_q;
  logic [ADDR_W-1:0]    pc_q;
  logic [INSTR_W-1:0]   ir_q;
  logic                 z_q;

  opcode_e              op;
  logic [3:0]           rd_f, rs1_f, rs2_f;
  logic [7:0]           imm8;
  logic [IDX_W-1:0]     rd_idx, rs1_idx, rs2_idx;
  logic [DATA_W-1:0]    rs1_val, rs2_val;
  logic [DATA_W-1:0]    alu_res, rf_wdata;
  logic                 rf_we, is_alu;
  logic [ADDR_W-1:0]    pc_inc, bz_off;

  assign op      = opcode_e'(ir_q[OP_MSB:OP_LSB]);
  assign rd_f    = ir_q[RD_MSB:RD_LSB];
  assign rs1_f   = ir_q[RS1_MSB:RS1_LSB];
  assign rs2_f   = ir_q[RS2_MSB:RS2_LSB];
  assign imm8    = ir_q[IMM_MSB:IMM_LSB];
  // Upper index bits are ignored, so r15 aliases r(NUM_REGS-1) etc.
  assign rd_idx  = IDX_W'(rd_f);
  assign rs1_idx = IDX_W'(rs1_f);
  assign rs2_idx = IDX_W'(rs2_f);

  assign is_alu  = op inside {OP_ADD, OP_SUB, OP_AND, OP_OR, OP_XOR};
  assign pc_inc  = pc_q + ADDR_W'(1);
  assign bz_off  = ADDR_W'($signed(imm8));

  always_comb begin
    alu_res = '0;
    unique case (op)
      OP_ADD:  alu_res = rs1_val + rs2_val;
      OP_SUB:  alu_res = rs1_val - rs2_val;
      OP_AND:  alu_res = rs1_val & rs2_val;
      OP_OR:   alu_res = rs1_val | rs2_val;
      OP_XOR:  alu_res = rs1_val ^ rs2_val;
      default: alu_res = '0;
    endcase
  end

  always_comb begin
    rf_we    = 1'b0;
    rf_wdata = alu_res;
    if (state_q == S_EXEC && (is_alu || op == OP_LDI)) begin
      rf_we = 1'b1;
      if (op == OP_LDI) rf_wdata = DATA_W'(imm8);
    end else if (state_q == S_MEM && op == OP_LD && mem_ack_i) begin
      rf_we    = 1'b1;
      rf_wdata = mem_rdata_i;
    end
  end

  register_file_n #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS)
  ) u_rf (
    .clk       (clk),
    .reset_i   (reset_i),
    .we_i      (rf_we),
    .waddr_i   (rd_idx),
    .wdata_i   (rf_wdata),
    .raddr_a_i (rs1_idx),
    .raddr_b_i (rs2_idx),
    .rdata_a_o (rs1_val),
    .rdata_b_o (rs2_val)
  );

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_q <= S_FETCH;
      pc_q    <= '0;
      ir_q    <= '0;
      z_q     <= 1'b0;
    end else begin
      unique case (state_q)
        S_FETCH: begin
          if (mem_ack_i) begin
            ir_q    <= mem_rdata_i[INSTR_W-1:0];
            state_q <= S_EXEC;
          end
        end
        S_EXEC: begin
          state_q <= S_FETCH;
          pc_q    <= pc_inc;
          if (is_alu) z_q <= (alu_res == '0);
          case (op)
            OP_BZ:        if (z_q) pc_q <= pc_q + bz_off;
            OP_JR:        pc_q <= ADDR_W'(rs1_val);
            OP_LD, OP_ST: begin
              state_q <= S_MEM;
              pc_q    <= pc_q;
            end
            OP_HALT: begin
              state_q <= S_HALT;
              pc_q    <= pc_q;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          if (mem_ack_i) begin
            pc_q    <= pc_inc;
            state_q <= S_FETCH;
          end
        end
        default: ;
      endcase
    end
  end

  // Reset leaves the state in FETCH, so the request is masked by reset_i to
  // keep it low while reset is held and drop it immediately on assertion.
  assign mem_req_o   = (state_q == S_FETCH || state_q == S_MEM) && !reset_i;
  assign mem_we_o    = (state_q == S_MEM) && (op == OP_ST);
  assign mem_addr_o  = (state_q == S_MEM) ? ADDR_W'(rs1_val) : pc_q;
  assign mem_wdata_o = ((state_q == S_MEM) && (op == OP_ST)) ? rs2_val : '0;
  assign halted_o    = (state_q == S_HALT);
  assign pc_o        = pc_q;

endmodule

// File: tb/tb_processor_mc.sv
module tb_processor_mc;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 16;
  localparam int unsigned NR = 8;

  logic          clk = 1'b0;
  logic          reset_i = 1'b1;
  logic          mem_req_o, mem_we_o, mem_ack_i, halted_o;
  logic [AW-1:0] mem_addr_o, pc_o;
  logic [DW-1:0] mem_wdata_o, mem_rdata_i;

  always #5 clk = ~clk;

  processor_mc #(.DATA_W(DW), .ADDR_W(AW), .NUM_REGS(NR)) dut (
    .clk         (clk),
    .reset_i     (reset_i),
    .mem_req_o   (mem_req_o),
    .mem_we_o    (mem_we_o),
    .mem_addr_o  (mem_addr_o),
    .mem_wdata_o (mem_wdata_o),
    .mem_rdata_i (mem_rdata_i),
    .mem_ack_i   (mem_ack_i),
    .halted_o    (halted_o),
    .pc_o        (pc_o)
  );

  typedef struct packed {
    logic          we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } txn_t;

  txn_t          exp_q[$];
  logic [DW-1:0] mem_dut [int unsigned];
  logic [DW-1:0] mem_ref [int unsigned];
  int unsigned   total = 0;
  int unsigned   bad = 0;
  int unsigned   wait_cfg = 0;
  bit            hold_st = 0;
  bit            expect_halt = 0;
  logic          ack_r = 1'b0;
  logic          late_ack = 1'b0;
  logic [DW-1:0] rdata_r = '0;

  assign mem_ack_i   = ack_r | late_ack;
  assign mem_rdata_i = rdata_r;

  function automatic void check(string name, logic [63:0] act, logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h t=%0t", name, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] rd_dut(int unsigned a);
    return mem_dut.exists(a) ? mem_dut[a] : '0;
  endfunction

  function automatic logic [DW-1:0] rd_ref(int unsigned a);
    return mem_ref.exists(a) ? mem_ref[a] : '0;
  endfunction

  task automatic load(input int unsigned a, input logic [DW-1:0] v);
    mem_dut[a] = v;
    mem_ref[a] = v;
  endtask

  task automatic clear_mem();
    mem_dut.delete();
    mem_ref.delete();
  endtask

  // Instruction-set interpreter: expected bus transactions go to exp_q,
  // cycles follows 2 per instruction, +1 for LD/ST, +w per transfer.
  task automatic run_model(input int unsigned w, output bit halted, output int unsigned cycles);
    logic [DW-1:0] r [NR];
    logic          z;
    logic [AW-1:0] pc;
    logic [15:0]   ir;
    logic [DW-1:0] a, b, res;
    int unsigned   rd;
    txn_t          t;
    for (int i = 0; i < NR; i++) r[i] = '0;
    z = 0; pc = '0; halted = 0; cycles = 0;
    for (int step = 0; step < 300; step++) begin
      t.we = 0; t.addr = pc; t.wdata = '0;
      exp_q.push_back(t);
      ir = rd_ref(pc)[15:0];
      cycles += 2 + w;
      rd = ir[11:8] % NR;
      a  = r[ir[7:4] % NR];
      b  = r[ir[3:0] % NR];
      case (ir[15:12])
        4'h1, 4'h2, 4'h3, 4'h4, 4'h5: begin
          case (ir[15:12])
            4'h1: res = a + b;
            4'h2: res = a - b;
            4'h3: res = a & b;
            4'h4: res = a | b;
            default: res = a ^ b;
          endcase
          r[rd] = res;
          z = (res == 0);
          pc = pc + 1;
        end
        4'h6: begin r[rd] = DW'(ir[7:0]); pc = pc + 1; end
        4'h7: begin
          t.we = 0; t.addr = a[AW-1:0]; t.wdata = '0;
          exp_q.push_back(t);
          cycles += 1 + w;
          r[rd] = rd_ref(a[AW-1:0]);
          pc = pc + 1;
        end
        4'h8: begin
          t.we = 1; t.addr = a[AW-1:0]; t.wdata = b;
          exp_q.push_back(t);
          cycles += 1 + w;
          mem_ref[a[AW-1:0]] = b;
          pc = pc + 1;
        end
        4'h9: begin
          if (z) pc = AW'(int'(pc) + int'($signed(ir[7:0])));
          else   pc = pc + 1;
        end
        4'hA: pc = a[AW-1:0];
        4'hF: begin halted = 1; break; end
        default: pc = pc + 1;
      endcase
    end
  endtask

  // Memory responder and scoreboard monitor.
  initial begin
    int unsigned wcnt;
    wcnt = 0;
    forever begin
      @(negedge clk);
      ack_r = 1'b0;
      if (reset_i || !mem_req_o) begin
        wcnt = 0;
        continue;
      end
      if (exp_q.size() == 0) begin
        if (expect_halt) check("unexpected_req", 64'(mem_req_o), 64'd0);
        continue;
      end
      check("req_we", 64'(mem_we_o), 64'(exp_q[0].we));
      check("req_addr", 64'(mem_addr_o), 64'(exp_q[0].addr));
      if (exp_q[0].we) check("req_wdata", 64'(mem_wdata_o), 64'(exp_q[0].wdata));
      if (hold_st && mem_we_o) continue;
      if (wcnt < wait_cfg) begin
        wcnt++;
        continue;
      end
      ack_r   = 1'b1;
      rdata_r = rd_dut(mem_addr_o);
      if (mem_we_o) mem_dut[mem_addr_o] = mem_wdata_o;
      void'(exp_q.pop_front());
      wcnt = 0;
    end
  end

  task automatic do_reset();
    @(posedge clk);
    #1 reset_i = 1'b1;
    @(posedge clk);
    #1;
  endtask

  // Runs whatever program is loaded; returns measured halt cycle count.
  task automatic run_prog(input int unsigned w, output int unsigned cyc_act);
    bit          halted;
    int unsigned cyc_exp;
    bit          done;
    exp_q.delete();
    wait_cfg = w;
    run_model(w, halted, cyc_exp);
    expect_halt = halted;
    check("rst_req", 64'(mem_req_o), 64'd0);
    check("rst_we", 64'(mem_we_o), 64'd0);
    check("rst_addr", 64'(mem_addr_o), 64'd0);
    check("rst_wdata", 64'(mem_wdata_o), 64'd0);
    check("rst_halted", 64'(halted_o), 64'd0);
    check("rst_pc", 64'(pc_o), 64'd0);
    @(posedge clk);
    #1 reset_i = 1'b0;
    #1;
    check("first_fetch_req", 64'(mem_req_o), 64'd1);
    check("first_fetch_we", 64'(mem_we_o), 64'd0);
    check("first_fetch_addr", 64'(mem_addr_o), 64'd0);
    cyc_act = 0;
    done = 0;
    for (int unsigned c = 1; c <= cyc_exp + 50; c++) begin
      @(posedge clk);
      #1;
      if (halted && halted_o) begin cyc_act = c; done = 1; break; end
      if (!halted && exp_q.size() == 0) begin done = 1; break; end
    end
    if (halted) begin
      check("halt_reached", 64'(done), 64'd1);
      check("halt_cycles", 64'(cyc_act), 64'(cyc_exp));
      for (int i = 0; i < 4; i++) begin
        @(posedge clk);
        #1 check("idle_after_halt", 64'(mem_req_o), 64'd0);
      end
      check("pending_txns", 64'(exp_q.size()), 64'd0);
      foreach (mem_ref[k]) check("mem_final", 64'(rd_dut(k)), 64'(mem_ref[k]));
    end else begin
      check("drain", 64'(exp_q.size()), 64'd0);
    end
    expect_halt = 0;
    do_reset();
  endtask

  task automatic load_base_prog();
    clear_mem();
    load(0, 32'h6105); // LDI r1,5
    load(1, 32'h6203); // LDI r2,3
    load(2, 32'h1312); // ADD r3,r1,r2
    load(3, 32'h8003); // ST [r0],r3
    load(4, 32'hF000); // HALT
  endtask

  task automatic gen_random();
    logic [15:0] ins;
    int unsigned k;
    clear_mem();
    for (int unsigned i = 0; i < 16; i++) begin
      k = $urandom_range(0, 10);
      ins = 16'($urandom);
      case (k)
        0:  ins[15:12] = 4'h6;
        1, 2, 3, 4, 5: ins[15:12] = 4'(k);
        6:  ins[15:12] = 4'h7;
        7:  ins[15:12] = 4'h8;
        8:  ins = {4'h9, 4'h0, 8'($urandom_range(1, 4))};
        9:  ins[15:12] = 4'(11 + $urandom_range(0, 3));
        default: ins[15:12] = 4'hA;
      endcase
      load(i, {16'($urandom), ins});
    end
    load(16, {16'($urandom), 16'hF000});
    for (int unsigned a = 32; a < 48; a++) load(a, DW'($urandom));
  endtask

  initial begin
    int unsigned cyc;
    #1;
    // Baseline program, zero wait.
    load_base_prog();
    run_prog(0, cyc);
    check("base_cycles", 64'(cyc), 64'd11);
    check("base_mem0", 64'(rd_dut(0)), 64'd8);

    // Same program with three wait states per transfer.
    load_base_prog();
    run_prog(3, cyc);
    check("wait_mem0", 64'(rd_dut(0)), 64'd8);

    // BZ -2 taken from address 1 wraps to 0xFFFF.
    clear_mem();
    load(0, 32'h2111);
    load(1, 32'h90FE);
    load(16'hFFFF, 32'hF000);
    run_prog(1, cyc);

    // BZ with Z still clear after reset falls through.
    clear_mem();
    load(0, 32'h0000);
    load(1, 32'h90FE);
    load(2, 32'hF000);
    run_prog(0, cyc);

    // 32 doublings of 0xFF wrap to zero; r15 aliases r7.
    clear_mem();
    load(0, 32'h6150);
    load(1, 32'h67FF);
    for (int unsigned i = 0; i < 24; i++) load(2 + i, (i % 2 == 1) ? 32'h1FFF : 32'h1777);
    load(26, 32'h801F);
    for (int unsigned i = 0; i < 8; i++) load(27 + i, 32'h1777);
    load(35, 32'h9002);
    load(36, 32'hF000);
    load(37, 32'h8007);
    load(38, 32'hF000);
    run_prog(0, cyc);
    check("wrap_mid", 64'(rd_dut(32'h50)), 64'hFF000000);
    check("wrap_zero", 64'(rd_dut(0)), 64'd0);

    // JR to 0x1234 after an undefined opcode.
    clear_mem();
    load(0, 32'h6180);
    load(1, 32'h7210);
    load(2, 32'hC123);
    load(3, 32'hA020);
    load(32'h80, 32'h1234);
    load(32'h1234, 32'h8001);
    load(32'h1235, 32'hF000);
    run_prog(2, cyc);
    check("jr_r1_kept", 64'(rd_dut(0)), 64'h80);

    // Reset asserted while an ST waits for its ack.
    clear_mem();
    load(0, 32'h6140);
    load(1, 32'h6209);
    load(2, 32'h8012);
    load(3, 32'hF000);
    begin
      bit          h;
      int unsigned c;
      bit          seen;
      exp_q.delete();
      wait_cfg = 0;
      hold_st = 1;
      run_model(0, h, c);
      expect_halt = 1;
      @(posedge clk);
      #1 reset_i = 1'b0;
      seen = 0;
      for (int i = 0; i < 40; i++) begin
        @(posedge clk);
        #1;
        if (mem_req_o && mem_we_o) begin seen = 1; break; end
      end
      check("st_wait_seen", 64'(seen), 64'd1);
      @(posedge clk);
      @(posedge clk);
      #3 reset_i = 1'b1;
      #1 check("req_drop_async", 64'(mem_req_o), 64'd0);
      expect_halt = 0;
      late_ack = 1'b1;
      @(posedge clk);
      @(posedge clk);
      #1 late_ack = 1'b0;
      hold_st = 0;
      check("st_not_done", 64'(rd_dut(32'h40)), 64'd0);
    end
    clear_mem();
    load(0, 32'h6140);
    load(1, 32'h6209);
    load(2, 32'h8012);
    load(3, 32'hF000);
    run_prog(0, cyc);
    check("after_rst_mem", 64'(rd_dut(32'h40)), 64'd9);

    // Randomised programs with random wait states.
    for (int n = 0; n < 8; n++) begin
      gen_random();
      run_prog($urandom_range(0, 3), cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1, "timeout");
  end

endmodule
